// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: register map, bit positions, FSM encoding and the underrun
// fill byte shared by the SPI slave peripheral.
package spi_slave_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int STAT_RX_FULL = 0;
  localparam int STAT_TX_FULL = 1;
  localparam int STAT_OVERRUN = 2;
  localparam int STAT_BUSY    = 3;

  localparam int CTRL_RXIE = 0;
  localparam int CTRL_TXIE = 1;

  localparam logic [7:0] UNDERRUN_FILL = 8'hFF;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } spi_state_e;

  // Byte to put on the wire for the next frame: the CPU byte if one is
  // waiting, otherwise the all-ones underrun filler.
  function automatic logic [7:0] tx_next_byte(input logic tx_full, input logic [7:0] tx_buf);
    return tx_full ? tx_buf : UNDERRUN_FILL;
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: 2-FF synchronizer for one asynchronous SPI pin, plus a
// history flop so rising/falling edges of the synchronized value can be seen.
// All stages reset low; the top decides what a low level means after reset.
module spi_slave_sync (
  input  logic CLK,
  input  logic RSTn,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Two synchronizing stages followed by the edge-detect history stage
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign dout = sync;
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: mode-0, MSB-first, 8-bit SPI slave on the AHB-lite bus with a
// one-byte RX buffer, one-byte TX buffer and a level interrupt.
// Optional feature macro: SPI_SLAVE_TXIRQ_EN (adds CTRL.TXIE and the
// "TX buffer empty while selected" interrupt source).
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter logic [31:0] spi_slave_addr = 32'h40003000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        SCK,
  input  logic        SSn,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        SPI_SEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        IRQ
);

  logic sck_sync, sck_rise, sck_fall;
  logic ssn_sync, ssn_rise, ssn_fall;
  logic mosi_sync, mosi_rise, mosi_fall;

  spi_slave_sync u_sck_sync (
    .CLK(CLK), .RSTn(RSTn), .din(SCK),
    .dout(sck_sync), .rise(sck_rise), .fall(sck_fall)
  );

  spi_slave_sync u_ssn_sync (
    .CLK(CLK), .RSTn(RSTn), .din(SSn),
    .dout(ssn_sync), .rise(ssn_rise), .fall(ssn_fall)
  );

  spi_slave_sync u_mosi_sync (
    .CLK(CLK), .RSTn(RSTn), .din(MOSI),
    .dout(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Only HADDR[3:2], HWDATA[7:0] and the SSn/SCK edges carry meaning here
  logic unused_ok;
  assign unused_ok = ^{spi_slave_addr, HADDR[31:4], HADDR[1:0], HWDATA[31:8],
                       sck_sync, mosi_rise, mosi_fall};

  // ---------------------------------------------------------------- bus
  logic       dphase;
  logic       dwrite;
  logic [1:0] doff;

  // Capture the address phase so the next cycle can act as the data phase
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      dphase <= 1'b0;
      dwrite <= 1'b0;
      doff   <= 2'd0;
    end else begin
      dphase <= SPI_SEL;
      if (SPI_SEL) begin
        dwrite <= HWRITE;
        doff   <= HADDR[3:2];
      end
    end
  end

  logic rd_data, wr_data, wr_status, wr_ctrl;
  assign rd_data   = dphase & ~dwrite & (doff == REG_DATA);
  assign wr_data   = dphase &  dwrite & (doff == REG_DATA);
  assign wr_status = dphase &  dwrite & (doff == REG_STATUS);
  assign wr_ctrl   = dphase &  dwrite & (doff == REG_CTRL);

  // ---------------------------------------------------------------- FSM
  spi_state_e state, state_nxt;

  // State register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // A frame is bounded by the synchronized SSn falling and rising edges
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (ssn_fall) state_nxt = S_ACTIVE;
      S_ACTIVE: if (ssn_rise) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- shifters
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [3:0] bit_cnt;
  logic       rx_done;
  logic [7:0] tx_buf;
  logic       tx_full;

  logic frame_start, frame_abort, rx_bit, tx_bit, tx_reload;
  assign frame_start = (state == S_IDLE) & ssn_fall;
  assign frame_abort = (state == S_ACTIVE) & ssn_rise;
  assign rx_bit      = (state == S_ACTIVE) & ~ssn_rise & sck_rise;
  assign tx_bit      = (state == S_ACTIVE) & ~ssn_rise & sck_fall;
  assign tx_reload   = frame_start | (tx_bit & (bit_cnt == 4'd8));

  // Shift registers and bit counter; the falling edge after the 8th bit
  // reloads tx_shift so a master can clock bytes back to back
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tx_shift <= 8'h00;
      rx_shift <= 8'h00;
      bit_cnt  <= 4'd0;
      rx_done  <= 1'b0;
    end else begin
      rx_done <= rx_bit & (bit_cnt == 4'd7);
      if (frame_start) begin
        tx_shift <= tx_next_byte(tx_full, tx_buf);
        bit_cnt  <= 4'd0;
      end else if (frame_abort) begin
        bit_cnt <= 4'd0;
      end else if (rx_bit) begin
        rx_shift <= {rx_shift[6:0], mosi_sync};
        bit_cnt  <= bit_cnt + 4'd1;
      end else if (tx_bit) begin
        if (bit_cnt == 4'd8) begin
          tx_shift <= tx_next_byte(tx_full, tx_buf);
          bit_cnt  <= 4'd0;
        end else begin
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

  // ---------------------------------------------------------------- buffers
  logic [7:0] rx_buf;
  logic       rx_full;
  logic       overrun;
  logic       ovr_set;

  // A completed byte is only dropped if the old one is still unread and is
  // not being read in this very cycle
  assign ovr_set = rx_done & rx_full & ~rd_data;

  // RX/TX buffers and status flags; a CPU write to DATA wins over a reload
  // happening in the same cycle, which itself used the old buffer
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rx_buf  <= 8'h00;
      rx_full <= 1'b0;
      tx_buf  <= 8'h00;
      tx_full <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (rx_done && !ovr_set) begin
        rx_buf  <= rx_shift;
        rx_full <= 1'b1;
      end else if (rd_data) begin
        rx_full <= 1'b0;
      end
      if (ovr_set) overrun <= 1'b1;
      else if (wr_status && HWDATA[STAT_OVERRUN]) overrun <= 1'b0;
      if (tx_reload && tx_full) tx_full <= 1'b0;
      if (wr_data) begin
        tx_buf  <= HWDATA[7:0];
        tx_full <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- busy
  // The SSn synchronizer resets low, so BUSY is held off until SSn has been
  // seen high once; this also keeps a frame from starting after reset
  // until the master produces a genuine falling edge.
  logic ssn_seen_high;
  logic busy;

  // Remember that SSn has been observed deasserted since reset
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)         ssn_seen_high <= 1'b0;
    else if (ssn_sync) ssn_seen_high <= 1'b1;
  end

  assign busy = ~ssn_sync & ssn_seen_high;

  // ---------------------------------------------------------------- CTRL
  logic ctrl_rxie;
  logic txie_en;

`ifdef SPI_SLAVE_TXIRQ_EN
  logic ctrl_txie;

  // Interrupt enables, RX and TX
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ctrl_rxie <= 1'b0;
      ctrl_txie <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_rxie <= HWDATA[CTRL_RXIE];
      ctrl_txie <= HWDATA[CTRL_TXIE];
    end
  end

  assign txie_en = ctrl_txie;
`else
  // Interrupt enable, RX only
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)        ctrl_rxie <= 1'b0;
    else if (wr_ctrl) ctrl_rxie <= HWDATA[CTRL_RXIE];
  end

  assign txie_en = 1'b0;
`endif

  // ---------------------------------------------------------------- IRQ
  // Registered interrupt so it trails the flags by one cycle
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) IRQ <= 1'b0;
`ifdef SPI_SLAVE_TXIRQ_EN
    else       IRQ <= (ctrl_rxie & rx_full) | (txie_en & ~tx_full & busy);
`else
    else       IRQ <= ctrl_rxie & rx_full;
`endif
  end

  // ---------------------------------------------------------------- outputs
  assign MISO = (state == S_ACTIVE) ? tx_shift[7] : 1'b0;

  logic [31:0] rd_mux;

  // Read data for the registered offset, driven only in a read data phase
  always_comb begin
    rd_mux = 32'h0;
    case (doff)
      REG_DATA: rd_mux[7:0] = rx_buf;
      REG_STATUS: begin
        rd_mux[STAT_RX_FULL] = rx_full;
        rd_mux[STAT_TX_FULL] = tx_full;
        rd_mux[STAT_OVERRUN] = overrun;
        rd_mux[STAT_BUSY]    = busy;
      end
      REG_CTRL: begin
        rd_mux[CTRL_RXIE] = ctrl_rxie;
        rd_mux[CTRL_TXIE] = txie_en;
      end
      default: rd_mux = 32'h0;
    endcase
    HRDATA = (dphase && !dwrite) ? rd_mux : 32'h0;
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed self-checking bench for spi_slave. Plays an SPI
// mode-0 master at CLK/8 and a simple AHB-lite CPU.
module tb_spi_slave;

  localparam logic [31:0] BASE = 32'h40003000;
  localparam logic [3:0]  OFF_DATA   = 4'h0;
  localparam logic [3:0]  OFF_STATUS = 4'h4;
  localparam logic [3:0]  OFF_CTRL   = 4'h8;

  logic        CLK = 1'b0;
  logic        RSTn, SCK, SSn, MOSI, MISO, SPI_SEL, HWRITE, IRQ;
  logic [31:0] HADDR, HWDATA, HRDATA;

  int checkCount = 0;
  int failCount  = 0;

  always #5 CLK = ~CLK;

  spi_slave dut (
    .CLK(CLK), .RSTn(RSTn), .SCK(SCK), .SSn(SSn), .MOSI(MOSI), .MISO(MISO),
    .SPI_SEL(SPI_SEL), .HADDR(HADDR), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .IRQ(IRQ)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic busWrite(input logic [3:0] off, input logic [31:0] data);
    @(negedge CLK);
    SPI_SEL = 1'b1; HADDR = BASE | {28'h0, off}; HWRITE = 1'b1;
    @(negedge CLK);
    SPI_SEL = 1'b0; HWRITE = 1'b0; HWDATA = data;
    @(negedge CLK);
  endtask

  task automatic busRead(input logic [3:0] off, output logic [31:0] data);
    @(negedge CLK);
    SPI_SEL = 1'b1; HADDR = BASE | {28'h0, off}; HWRITE = 1'b0;
    @(negedge CLK);
    SPI_SEL = 1'b0;
    data = HRDATA;
  endtask

  task automatic readCheck(input string tag, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] d;
    busRead(off, d);
    checkOutput(tag, d, exp);
  endtask

  // Mode-0 master: drive MOSI while SCK low, sample MISO just before rising
  task automatic applyStimulus(input logic [7:0] txByte, input int nBits, output logic [7:0] rxByte);
    rxByte = 8'h00;
    for (int i = 0; i < nBits; i++) begin
      MOSI = txByte[7-i];
      repeat (4) @(negedge CLK);
      rxByte = {rxByte[6:0], MISO};
      SCK = 1'b1;
      repeat (4) @(negedge CLK);
      SCK = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] txByte, output logic [7:0] rxByte);
    SSn = 1'b0;
    idle(2);
    applyStimulus(txByte, 8, rxByte);
    idle(6);
    SSn = 1'b1;
    idle(4);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] m, m1, m2;

    RSTn = 1'b0; SCK = 1'b0; SSn = 1'b1; MOSI = 1'b0;
    SPI_SEL = 1'b0; HADDR = 32'h0; HWRITE = 1'b0; HWDATA = 32'h0;
    idle(3);
    checkOutput("reset_miso", {31'h0, MISO}, 32'h0);
    checkOutput("reset_hrdata", HRDATA, 32'h0);
    checkOutput("reset_irq", {31'h0, IRQ}, 32'h0);
    RSTn = 1'b1;
    idle(4);
    readCheck("reset_status", OFF_STATUS, 32'h0);
    readCheck("reset_ctrl", OFF_CTRL, 32'h0);
    readCheck("reset_data", OFF_DATA, 32'h0);
    readCheck("reserved_0xC", 4'hC, 32'h0);

    $display("[TB] basic exchange");
    busWrite(OFF_DATA, 32'h0000005A);
    readCheck("basic_status_txfull", OFF_STATUS, 32'h2);
    SSn = 1'b0;
    idle(2);
    applyStimulus(8'hC3, 8, m);
    checkOutput("basic_miso", {24'h0, m}, 32'h5A);
    idle(6);
    readCheck("basic_status_busy", OFF_STATUS, 32'h9);
    SSn = 1'b1;
    idle(4);
    readCheck("basic_data", OFF_DATA, 32'hC3);
    readCheck("basic_status_after", OFF_STATUS, 32'h0);

    $display("[TB] underrun");
    frame(8'h01, m);
    checkOutput("underrun_miso", {24'h0, m}, 32'hFF);
    readCheck("underrun_data", OFF_DATA, 32'h01);

    $display("[TB] overrun");
    frame(8'h11, m);
    frame(8'h22, m);
    readCheck("overrun_status", OFF_STATUS, 32'h5);
    readCheck("overrun_data", OFF_DATA, 32'h11);
    busWrite(OFF_STATUS, 32'h4);
    readCheck("overrun_cleared", OFF_STATUS, 32'h0);

    $display("[TB] abort");
    SSn = 1'b0;
    idle(2);
    applyStimulus(8'hFF, 5, m);
    idle(2);
    SSn = 1'b1;
    idle(4);
    readCheck("abort_status", OFF_STATUS, 32'h0);
    frame(8'hA5, m);
    readCheck("abort_full_status", OFF_STATUS, 32'h1);
    readCheck("abort_data", OFF_DATA, 32'hA5);

    $display("[TB] back-to-back");
    busWrite(OFF_DATA, 32'h12);
    SSn = 1'b0;
    idle(2);
    fork
      applyStimulus(8'h55, 8, m1);
      begin
        logic [31:0] d;
        idle(20);
        busWrite(OFF_DATA, 32'h34);
        idle(50);
        busRead(OFF_DATA, d);
        checkOutput("b2b_data1", d, 32'h55);
      end
    join
    applyStimulus(8'hAA, 8, m2);
    idle(6);
    SSn = 1'b1;
    idle(4);
    checkOutput("b2b_miso1", {24'h0, m1}, 32'h12);
    checkOutput("b2b_miso2", {24'h0, m2}, 32'h34);
    readCheck("b2b_status", OFF_STATUS, 32'h1);
    readCheck("b2b_data2", OFF_DATA, 32'hAA);

    $display("[TB] irq");
    busWrite(OFF_CTRL, 32'h3);
`ifdef SPI_SLAVE_TXIRQ_EN
    readCheck("ctrl_readback", OFF_CTRL, 32'h3);
    checkOutput("irq_idle", {31'h0, IRQ}, 32'h0);
    SSn = 1'b0;
    idle(4);
    checkOutput("irq_tx_empty", {31'h0, IRQ}, 32'h1);
    SSn = 1'b1;
    idle(4);
    checkOutput("irq_tx_deselect", {31'h0, IRQ}, 32'h0);
`else
    readCheck("ctrl_readback", OFF_CTRL, 32'h1);
    checkOutput("irq_idle", {31'h0, IRQ}, 32'h0);
`endif
    busWrite(OFF_CTRL, 32'h1);
    frame(8'h3C, m);
    checkOutput("irq_rx", {31'h0, IRQ}, 32'h1);
    readCheck("irq_data", OFF_DATA, 32'h3C);
    idle(2);
    checkOutput("irq_cleared", {31'h0, IRQ}, 32'h0);

    $display("[TB] reset mid-frame");
    busWrite(OFF_DATA, 32'h0F);
    SSn = 1'b0;
    idle(2);
    busWrite(OFF_DATA, 32'h99);
    applyStimulus(8'hF0, 4, m);
    idle(4);
    checkOutput("midframe_miso_high", {31'h0, MISO}, 32'h1);
    RSTn = 1'b0;
    idle(1);
    checkOutput("midreset_miso", {31'h0, MISO}, 32'h0);
    RSTn = 1'b1;
    idle(2);
    applyStimulus(8'h5A, 8, m);
    idle(6);
    checkOutput("postreset_miso", {31'h0, MISO}, 32'h0);
    SSn = 1'b1;
    idle(4);
    readCheck("postreset_status", OFF_STATUS, 32'h0);
    readCheck("postreset_ctrl", OFF_CTRL, 32'h0);
    readCheck("postreset_data", OFF_DATA, 32'h0);
    frame(8'h81, m);
    checkOutput("fresh_miso", {24'h0, m}, 32'hFF);
    readCheck("fresh_data", OFF_DATA, 32'h81);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave peripheral on the AHB-lite data bus: the responder counterpart of `spi_master`, letting an external SPI master exchange bytes with the Cortex-M0. Operates in mode 0 (CPOL=0, CPHA=0) with 8-bit MSB-first frames. SCK, SSn and MOSI are oversampled in the CLK domain. Holds a one-byte RX buffer and a one-byte TX buffer, and raises IRQ when a byte has been received.

## Interface
- `spi_slave_addr`, default 32'h40003000: base address. Registers sit at base+0x0 (DATA), base+0x4 (STATUS) and base+0x8 (CTRL).
- `CLK`  in  1  system clock. Single clock domain.
- `RSTn`  in  1  reset, asynchronous, active-low.
- `SCK`  in  1  SPI clock from the external master, asynchronous to CLK.
- `SSn`  in  1  slave select, active-low, asynchronous.
- `MOSI`  in  1  master-output-slave-input.
- `MISO`  out  1  master-input-slave-output.
- `SPI_SEL`  in  1  address-phase select from `ahb_slave_mux`.
- `HADDR`  in  32  AHB address; only bits [3:2] are decoded.
- `HWRITE`  in  1  AHB write control.
- `HWDATA`  in  32  AHB write data, used in the data phase.
- `HRDATA`  out  32  read data, unused bits 0.
- `IRQ`  out  1  level interrupt to `IRQ[2]` of the core.

## Operation
- **Bus access**
  - With SPI_SEL high, HADDR[3:2] and HWRITE are registered (address phase).
  - In the following cycle (data phase), a write takes HWDATA and a read presents HRDATA from the registered offset.
  - Offset 0xC reads 0 and ignores writes.
- **DATA register**
  - Read returns {24'b0, rx_buf} and clears RX_FULL.
  - Write loads tx_buf from HWDATA[7:0] and sets TX_FULL.
- **STATUS register**
  - bit0 RX_FULL, bit1 TX_FULL, bit2 OVERRUN (sticky), bit3 BUSY (synchronized SSn low).
  - Writing 1 to bit2 clears OVERRUN. Other bits are read-only.
- **CTRL register**: bit0 RXIE, bit1 TXIE (TXIE exists only with the macro). Reset value 0.
- **Input synchronizers**: SCK, SSn and MOSI each pass through a 2-FF synchronizer. Edge detection is done on the synchronized value.
- **FSM states**: IDLE and ACTIVE.
  - IDLE → ACTIVE on synchronized SSn falling edge.
    - tx_shift is loaded with tx_buf if TX_FULL is set, and TX_FULL is cleared.
    - Otherwise tx_shift is loaded with 8'hFF (underrun; no flag).
    - bit_cnt is set to 0.
  - ACTIVE, SCK rising edge: rx_shift becomes {rx_shift[6:0], MOSI_sync}, and bit_cnt increments.
  - ACTIVE, SCK falling edge: tx_shift shifts left.
    - If bit_cnt == 8, tx_shift reloads from tx_buf or 8'hFF using the same rule as above, and bit_cnt is set to 0. This allows back-to-back bytes.
  - Completion of the 8th rising edge:
    - If RX_FULL is 0, rx_buf takes the full byte and RX_FULL is set.
    - If RX_FULL is 1, OVERRUN is set, the new byte is discarded and rx_buf is kept.
  - ACTIVE → IDLE on SSn rising edge. The partial byte is discarded with no flag change, and bit_cnt is set to 0.
- **MISO**: driven with tx_shift[7] in ACTIVE, 0 in IDLE.
- **IRQ**: (RXIE & RX_FULL), ORed with (TXIE & ~TX_FULL & BUSY) when the macro is defined.
- **Simultaneous events in one cycle**
  - A CPU DATA read and byte completion together: the new byte is stored and RX_FULL remains 1.
  - A CPU DATA write and tx_shift reload together: the reload uses the old buffer state, then the new tx_buf is written and TX_FULL is set.

## Timing
- Reset values:
  - MISO=0, HRDATA=0, IRQ=0.
  - All flags 0, CTRL=0, rx_buf=0, tx_buf=0, FSM in IDLE.
- Input-to-action latency is 3 CLK (2 synchronizer stages plus 1 edge-detect stage).
- MISO updates 3–4 CLK after a physical SCK falling edge or SSn falling edge.
- Constraints on the external master:
  - SCK high and low times ≥ 4 CLK each.
  - SSn falling to first SCK rising ≥ 5 CLK.
- RX_FULL is set 4 CLK after the 8th physical SCK rising edge.
- IRQ follows the flags by 1 CLK (registered output).
- RSTn assertion mid-frame returns the block to IDLE immediately. The next frame starts only on a fresh SSn falling edge.

## Configuration
- `SPI_SLAVE_TXIRQ_EN` defined:
  - CTRL bit1 (TXIE) is implemented.
  - IRQ also asserts while BUSY and the TX buffer is empty, so firmware can refill before the next byte.
- Macro undefined:
  - CTRL bit1 reads 0 and ignores writes.
  - IRQ depends on RX_FULL only.

## Structure
- Package `spi_slave_pkg` holds:
  - Register offsets (DATA, STATUS, CTRL).
  - STATUS/CTRL bit positions.
  - The FSM state encoding (IDLE/ACTIVE).
  - The underrun fill constant 8'hFF.
- Sub-module `spi_slave_sync` contains the 2-FF synchronizer plus rise/fall edge detect. It is instantiated three times (SCK, SSn, MOSI; edge outputs unused for MOSI).

## Test plan
- **Basic exchange**: write DATA=0x5A, SSn low, master sends 0xC3 at CLK/8 → MISO shifts out 0x5A, STATUS=0x9 while SSn low, DATA read=0x000000C3, RX_FULL then 0.
- **Underrun**: no TX write, master sends 0x01 → MISO carries 0xFF, rx_buf=0x01.
- **Overrun**: send 0x11 then 0x22 without reading → DATA reads 0x11, OVERRUN=1; writing 0x4 to STATUS clears it.
- **Abort**: SSn high after 5 bits, then a full frame of 0xA5 → RX_FULL only after the full frame, DATA=0xA5.
- **Back-to-back**: 2 bytes in one SSn window with tx_buf refilled between them (0x12, 0x34) → MISO carries 0x12 then 0x34.
- **IRQ and reset**: RXIE=1, receive a byte → IRQ=1 until DATA is read. With `SPI_SLAVE_TXIRQ_EN` defined, TXIE=1 and SSn low with TX empty → IRQ=1. RSTn pulse mid-byte → MISO=0, STATUS=0.
